// File: rtl/control.sv
// rtl/control.sv - registered instruction decode for the MIPS32-subset core
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] hint,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [5:0] alu_op,
  output logic       alu_src,
  output logic [2:0] dm_op,
  output logic       dm_wr,
  output logic       dm_rd,
  output logic [1:0] ext_op,
  output logic [3:0] pc_op,
  output logic [1:0] reg_src,
  output logic [1:0] reg_dst,
  output logic       reg_wr,
  output logic       reg_in,
  output logic       cop0_wr,
  output logic       cop0_rd,
  output logic [2:0] cop0_op
);

  localparam logic [5:0] ALU_ADD = 6'd0, ALU_ADDU = 6'd1, ALU_SUB = 6'd2, ALU_SUBU = 6'd3;
  localparam logic [5:0] ALU_AND = 6'd4, ALU_OR = 6'd5, ALU_XOR = 6'd6, ALU_NOR = 6'd7;
  localparam logic [5:0] ALU_SLT = 6'd8, ALU_SLTU = 6'd9, ALU_SLL = 6'd10, ALU_SRL = 6'd11;
  localparam logic [5:0] ALU_SRA = 6'd12, ALU_LUI = 6'd13;

  logic [5:0] n_alu_op;
  logic       n_alu_src;
  logic [2:0] n_dm_op;
  logic       n_dm_wr;
  logic       n_dm_rd;
  logic [1:0] n_ext_op;
  logic [3:0] n_pc_op;
  logic [1:0] n_reg_src;
  logic [1:0] n_reg_dst;
  logic       n_reg_wr;
  logic       n_reg_in;
  logic       n_cop0_wr;
  logic       n_cop0_rd;
  logic [2:0] n_cop0_op;

  // rd and the shift amount are routed by the datapath, never decoded here
  logic unused_fields;
  assign unused_fields = ^{rd, hint};

  always_comb begin
    n_alu_op  = 6'd0;
    n_alu_src = 1'b0;
    n_dm_op   = 3'd0;
    n_dm_wr   = 1'b0;
    n_dm_rd   = 1'b0;
    n_ext_op  = 2'd0;
    n_pc_op   = 4'd0;
    n_reg_src = 2'd0;
    n_reg_dst = 2'd0;
    n_reg_wr  = 1'b0;
    n_reg_in  = 1'b0;
    n_cop0_wr = 1'b0;
    n_cop0_rd = 1'b0;
    n_cop0_op = 3'd0;

    case (opcode)
      6'h00: begin
        if (funct inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
          n_reg_wr  = 1'b1;
          n_reg_dst = 2'd1;
        end
        case (funct)
          6'h20: n_alu_op = ALU_ADD;
          6'h21: n_alu_op = ALU_ADDU;
          6'h22: n_alu_op = ALU_SUB;
          6'h23: n_alu_op = ALU_SUBU;
          6'h24: n_alu_op = ALU_AND;
          6'h25: n_alu_op = ALU_OR;
          6'h26: n_alu_op = ALU_XOR;
          6'h27: n_alu_op = ALU_NOR;
          6'h2A: n_alu_op = ALU_SLT;
          6'h2B: n_alu_op = ALU_SLTU;
          6'h00: begin n_alu_op = ALU_SLL; n_reg_in = 1'b1; end
          6'h02: begin n_alu_op = ALU_SRL; n_reg_in = 1'b1; end
          6'h03: begin n_alu_op = ALU_SRA; n_reg_in = 1'b1; end
          6'h08: n_pc_op = 4'd2;
          6'h09: begin
            n_pc_op   = 4'd2;
            n_reg_wr  = 1'b1;
            n_reg_dst = 2'd1;
            n_reg_src = 2'd2;
          end
          6'h0C: begin n_pc_op = 4'd10; n_cop0_op = 3'd4; end
          default: ;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) n_pc_op = 4'd7;
        else if (rt == 5'd1) n_pc_op = 4'd8;
      end
      6'h02: n_pc_op = 4'd1;
      6'h03: begin
        n_pc_op   = 4'd1;
        n_reg_wr  = 1'b1;
        n_reg_dst = 2'd2;
        n_reg_src = 2'd2;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        n_pc_op  = 4'd3 + {2'b00, opcode[1:0]};
        n_ext_op = 2'd1;
        n_alu_op = ALU_SUBU;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        n_reg_wr  = 1'b1;
        n_alu_src = 1'b1;
        case (opcode[2:0])
          3'd0: begin n_alu_op = ALU_ADD;  n_ext_op = 2'd1; end
          3'd1: begin n_alu_op = ALU_ADDU; n_ext_op = 2'd1; end
          3'd2: begin n_alu_op = ALU_SLT;  n_ext_op = 2'd1; end
          3'd3: begin n_alu_op = ALU_SLTU; n_ext_op = 2'd1; end
          3'd4: n_alu_op = ALU_AND;
          3'd5: n_alu_op = ALU_OR;
          3'd6: n_alu_op = ALU_XOR;
          default: begin n_alu_op = ALU_LUI; n_ext_op = 2'd2; end
        endcase
      end
      6'h10: begin
        if (rs == 5'h00) begin
          n_cop0_rd = 1'b1;
          n_cop0_op = 3'd2;
          n_reg_wr  = 1'b1;
          n_reg_src = 2'd3;
        end else if (rs == 5'h04) begin
          n_cop0_wr = 1'b1;
          n_cop0_op = 3'd1;
        end else if (rs == 5'h10 && funct == 6'h18) begin
          n_pc_op   = 4'd9;
          n_cop0_op = 3'd3;
        end
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        n_dm_rd   = 1'b1;
        n_reg_wr  = 1'b1;
        n_reg_src = 2'd1;
        n_alu_src = 1'b1;
        n_ext_op  = 2'd1;
        n_alu_op  = ALU_ADDU;
        case (opcode[2:0])
          3'd0: n_dm_op = 3'd1;
          3'd1: n_dm_op = 3'd3;
          3'd4: n_dm_op = 3'd2;
          3'd5: n_dm_op = 3'd4;
          default: n_dm_op = 3'd0;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        n_dm_wr   = 1'b1;
        n_alu_src = 1'b1;
        n_ext_op  = 2'd1;
        n_alu_op  = ALU_ADDU;
        case (opcode[1:0])
          2'd0: n_dm_op = 3'd1;
          2'd1: n_dm_op = 3'd3;
          default: n_dm_op = 3'd0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= 6'd0;
      alu_src <= 1'b0;
      dm_op   <= 3'd0;
      dm_wr   <= 1'b0;
      dm_rd   <= 1'b0;
      ext_op  <= 2'd0;
      pc_op   <= 4'd0;
      reg_src <= 2'd0;
      reg_dst <= 2'd0;
      reg_wr  <= 1'b0;
      reg_in  <= 1'b0;
      cop0_wr <= 1'b0;
      cop0_rd <= 1'b0;
      cop0_op <= 3'd0;
    end else begin
      alu_op  <= n_alu_op;
      alu_src <= n_alu_src;
      dm_op   <= n_dm_op;
      dm_wr   <= n_dm_wr;
      dm_rd   <= n_dm_rd;
      ext_op  <= n_ext_op;
      pc_op   <= n_pc_op;
      reg_src <= n_reg_src;
      reg_dst <= n_reg_dst;
      reg_wr  <= n_reg_wr;
      reg_in  <= n_reg_in;
      cop0_wr <= n_cop0_wr;
      cop0_rd <= n_cop0_rd;
      cop0_op <= n_cop0_op;
    end
  end

endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - randomized table-driven check of the control decoder
module tb_control;

  typedef struct packed {
    logic [5:0] alu_op;
    logic       alu_src;
    logic [2:0] dm_op;
    logic       dm_wr;
    logic       dm_rd;
    logic [1:0] ext_op;
    logic [3:0] pc_op;
    logic [1:0] reg_src;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       reg_in;
    logic       cop0_wr;
    logic       cop0_rd;
    logic [2:0] cop0_op;
  } out_t;

  typedef struct {
    int   op;
    int   fn;
    int   rs;
    int   rt;
    out_t exp;
  } rule_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] instr_hint = '0, rs = '0, rt = '0, rd = '0;
  logic [5:0] alu_op;
  logic       alu_src, dm_wr, dm_rd, reg_wr, reg_in, cop0_wr, cop0_rd;
  logic [2:0] dm_op, cop0_op;
  logic [1:0] ext_op, reg_src, reg_dst;
  logic [3:0] pc_op;
  out_t       dut_o;

  int tests = 0;
  int fails = 0;
  rule_t rules[$];

  always #5 clk = ~clk;

  control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .hint(instr_hint),
    .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .alu_src(alu_src), .dm_op(dm_op),
    .dm_wr(dm_wr), .dm_rd(dm_rd), .ext_op(ext_op), .pc_op(pc_op), .reg_src(reg_src),
    .reg_dst(reg_dst), .reg_wr(reg_wr), .reg_in(reg_in), .cop0_wr(cop0_wr),
    .cop0_rd(cop0_rd), .cop0_op(cop0_op)
  );

  assign dut_o = {alu_op, alu_src, dm_op, dm_wr, dm_rd, ext_op, pc_op, reg_src,
                  reg_dst, reg_wr, reg_in, cop0_wr, cop0_rd, cop0_op};

  // argument order: alu, alu_src, dm_op, dm_wr, dm_rd, ext, pc, reg_src, reg_dst, reg_wr, reg_in, c0wr, c0rd, c0op
  function automatic out_t mk(int a, int asrc, int dmo, int dmw, int dmr, int ext, int pc,
                              int rsrc, int rdst, int rwr, int rin, int c0w, int c0r, int c0o);
    out_t e;
    e.alu_op = 6'(a);    e.alu_src = 1'(asrc); e.dm_op = 3'(dmo);  e.dm_wr = 1'(dmw);
    e.dm_rd = 1'(dmr);   e.ext_op = 2'(ext);   e.pc_op = 4'(pc);   e.reg_src = 2'(rsrc);
    e.reg_dst = 2'(rdst); e.reg_wr = 1'(rwr);  e.reg_in = 1'(rin); e.cop0_wr = 1'(c0w);
    e.cop0_rd = 1'(c0r); e.cop0_op = 3'(c0o);
    return e;
  endfunction

  function automatic void add(int op, int fn, int rsv, int rtv, out_t e);
    rule_t r;
    r.op = op; r.fn = fn; r.rs = rsv; r.rt = rtv; r.exp = e;
    rules.push_back(r);
  endfunction

  // Each legal encoding as a row; fields marked -1 are don't-care
  function automatic void build_rules();
    int arith_fn[10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int imm_alu[8]   = '{0, 1, 8, 9, 4, 5, 6, 13};
    int imm_ext[8]   = '{1, 1, 1, 1, 0, 0, 0, 2};
    int ld_op[5]     = '{'h20, 'h21, 'h23, 'h24, 'h25};
    int ld_dm[5]     = '{1, 3, 0, 2, 4};
    int st_op[3]     = '{'h28, 'h29, 'h2B};
    int st_dm[3]     = '{1, 3, 0};
    for (int i = 0; i < 10; i++) add(0, arith_fn[i], -1, -1, mk(i,0,0,0,0,0,0,0,1,1,0,0,0,0));
    add(0, 'h00, -1, -1, mk(10,0,0,0,0,0,0,0,1,1,1,0,0,0));
    add(0, 'h02, -1, -1, mk(11,0,0,0,0,0,0,0,1,1,1,0,0,0));
    add(0, 'h03, -1, -1, mk(12,0,0,0,0,0,0,0,1,1,1,0,0,0));
    add(0, 'h08, -1, -1, mk(0,0,0,0,0,0,2,0,0,0,0,0,0,0));
    add(0, 'h09, -1, -1, mk(0,0,0,0,0,0,2,2,1,1,0,0,0,0));
    add(0, 'h0C, -1, -1, mk(0,0,0,0,0,0,10,0,0,0,0,0,0,4));
    for (int i = 0; i < 8; i++) add('h08 + i, -1, -1, -1, mk(imm_alu[i],1,0,0,0,imm_ext[i],0,0,0,1,0,0,0,0));
    for (int i = 0; i < 5; i++) add(ld_op[i], -1, -1, -1, mk(1,1,ld_dm[i],0,1,1,0,1,0,1,0,0,0,0));
    for (int i = 0; i < 3; i++) add(st_op[i], -1, -1, -1, mk(1,1,st_dm[i],1,0,1,0,0,0,0,0,0,0,0));
    add('h02, -1, -1, -1, mk(0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    add('h03, -1, -1, -1, mk(0,0,0,0,0,0,1,2,2,1,0,0,0,0));
    for (int i = 0; i < 4; i++) add('h04 + i, -1, -1, -1, mk(3,0,0,0,0,1,3 + i,0,0,0,0,0,0,0));
    add('h01, -1, -1, 0, mk(0,0,0,0,0,0,7,0,0,0,0,0,0,0));
    add('h01, -1, -1, 1, mk(0,0,0,0,0,0,8,0,0,0,0,0,0,0));
    add('h10, -1, 'h00, -1, mk(0,0,0,0,0,0,0,3,0,1,0,0,1,2));
    add('h10, -1, 'h04, -1, mk(0,0,0,0,0,0,0,0,0,0,0,1,0,1));
    add('h10, 'h18, 'h10, -1, mk(0,0,0,0,0,0,9,0,0,0,0,0,0,3));
  endfunction

  function automatic out_t model(logic [5:0] op, logic [5:0] fn, logic [4:0] rsv, logic [4:0] rtv);
    foreach (rules[i]) begin
      if (rules[i].op == int'(op) && (rules[i].fn < 0 || rules[i].fn == int'(fn)) &&
          (rules[i].rs < 0 || rules[i].rs == int'(rsv)) && (rules[i].rt < 0 || rules[i].rt == int'(rtv)))
        return rules[i].exp;
    end
    return '0;
  endfunction

  task automatic drive(int op, int fn, int rsv, int rtv);
    opcode = 6'(op); funct = 6'(fn); rs = 5'(rsv); rt = 5'(rtv);
    rd = 5'($urandom); instr_hint = 5'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive('h00, 'h20, 1, 2);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dut_o !== out_t'(0)) begin
      $display("FAIL reset_hold got=%h exp=0", dut_o); fails++;
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (dut_o !== mk(0,0,0,0,0,0,0,0,1,1,0,0,0,0)) begin
      $display("FAIL reset_release_add got=%h", dut_o); fails++;
    end
  endtask

  task automatic test_async_reset();
    drive('h00, 'h20, 3, 4);
    step();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (dut_o !== out_t'(0)) begin
      $display("FAIL async_reset got=%h exp=0", dut_o); fails++;
    end
    step();
    #1 rst_n = 1'b1;
    step();
    tests++;
    if (alu_op !== 6'd0 || reg_wr !== 1'b1 || reg_dst !== 2'd1 || reg_src !== 2'd0 || pc_op !== 4'd0) begin
      $display("FAIL async_release_add got=%h", dut_o); fails++;
    end
  endtask

  task automatic test_directed();
    int ops[9] = '{'h00, 'h00, 'h00, 'h03, 'h20, 'h29, 'h3F, 'h01, 'h10};
    int fns[9] = '{'h20, 'h08, 'h09, 'h00, 'h00, 'h00, 'h00, 'h00, 'h18};
    int rss[9] = '{0, 31, 31, 0, 0, 0, 0, 0, 'h10};
    int rts[9] = '{0, 0, 0, 0, 0, 0, 0, 5, 0};
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], fns[i], rss[i], rts[i]);
      step();
      tests++;
      if (dut_o !== model(opcode, funct, rs, rt)) begin
        $display("FAIL directed_%0d got=%h exp=%h", i, dut_o, model(opcode, funct, rs, rt)); fails++;
      end
      if (i == 5) begin
        tests++;
        if (dm_wr !== 1'b1 || dm_op !== 3'd3 || reg_wr !== 1'b0) begin
          $display("FAIL sh_fields got=%h", dut_o); fails++;
        end
      end
      if (i >= 6 && i <= 7) begin
        tests++;
        if (dut_o !== out_t'(0)) begin
          $display("FAIL illegal_%0d got=%h exp=0", i, dut_o); fails++;
        end
      end
    end
  endtask

  task automatic test_hold();
    out_t e;
    drive('h23, 0, 0, 0);
    step();
    e = model(opcode, funct, rs, rt);
    drive('h2B, 0, 0, 0);
    #3;
    tests++;
    if (dut_o !== e) begin
      $display("FAIL hold_between_edges got=%h exp=%h", dut_o, e); fails++;
    end
    step();
    tests++;
    if (dut_o !== model('h2B, 0, 0, 0)) begin
      $display("FAIL hold_next_edge got=%h", dut_o); fails++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        rule_t r;
        r = rules[$urandom_range(rules.size() - 1, 0)];
        drive(r.op, r.fn < 0 ? int'($urandom_range(63, 0)) : r.fn,
              r.rs < 0 ? int'($urandom_range(31, 0)) : r.rs,
              r.rt < 0 ? int'($urandom_range(31, 0)) : r.rt);
      end else begin
        drive($urandom_range(63, 0), $urandom_range(63, 0), $urandom_range(31, 0), $urandom_range(31, 0));
      end
      e = model(opcode, funct, rs, rt);
      step();
      tests++;
      if (dut_o !== e) begin
        $display("FAIL random_%0d op=%h fn=%h rs=%h rt=%h got=%h exp=%h",
                 n, opcode, funct, rs, rt, dut_o, e);
        fails++;
      end
    end
  endtask

  initial begin
    build_rules();
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
